// File: rtl/serial_deser_reg_if.sv
// Serial-in / parallel-out bus between a bit-stream source and a word consumer.
// The slave modport is the deserializer's view; the master modport is the driver's view.
interface serial_deser_reg_if #(
    parameter int WIDTH = 16
);
    logic             clr;
    logic             sin;
    logic             sin_valid;
    logic             sof;
    logic             msb_first;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overflow;
    logic             parity_err;

    modport master (
        output clr, sin, sin_valid, sof, msb_first, dout_ready,
        input  dout, dout_valid, busy, overflow, parity_err
    );

    modport slave (
        input  clr, sin, sin_valid, sof, msb_first, dout_ready,
        output dout, dout_valid, busy, overflow, parity_err
    );
endinterface

// File: rtl/serial_deser_reg.sv
// Deserializer: assembles sof-framed serial bits into WIDTH-bit words behind a one-entry valid/ready buffer.
// Define DESER_PARITY_EN to expect a trailing even-parity bit after each word.
module serial_deser_reg #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rstn,
    serial_deser_reg_if.slave   bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             order_q, order_d;
    logic             word_done;
    logic [WIDTH-1:0] word_d;
    logic             load_word;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             overflow_q;

    // The first bit of a word always ends up in dout[WIDTH-1] (msb) or dout[0] (lsb).
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             b,
                                                  input logic             msb);
        return msb ? {cur[WIDTH-2:0], b} : {b, cur[WIDTH-1:1]};
    endfunction

`ifdef DESER_PARITY_EN
    logic par_bad_d;
    logic parity_err_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            order_q <= order_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        order_d   = order_q;
        word_done = 1'b0;
        word_d    = shift_q;
`ifdef DESER_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (bus.sin_valid) begin
            // A qualified sof restarts assembly from any state, dropping a partial word.
            if (bus.sof) begin
                order_d = bus.msb_first;
                shift_d = shift_in('0, bus.sin, bus.msb_first);
                count_d = CW'(1);
                state_d = RECV;
            end else begin
                case (state_q)
                    RECV: begin
                        shift_d = shift_in(shift_q, bus.sin, order_q);
                        if (count_q == LAST) begin
`ifdef DESER_PARITY_EN
                            count_d = count_q + CW'(1);
                            state_d = PAR;
`else
                            word_done = 1'b1;
                            word_d    = shift_d;
                            count_d   = '0;
                            state_d   = IDLE;
`endif
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
`ifdef DESER_PARITY_EN
                    PAR: begin
                        word_done = 1'b1;
                        word_d    = shift_q;
                        par_bad_d = ^{shift_q, bus.sin};
                        count_d   = '0;
                        state_d   = IDLE;
                    end
`endif
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // A completing word may replace a word being consumed on the same edge.
    assign load_word = word_done && (!dout_valid_q || bus.dout_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (bus.clr) begin
                overflow_q <= 1'b0;
            end
            if (word_done) begin
                if (load_word) begin
                    dout_q       <= word_d;
                    dout_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Parity travels with the buffered word; a dropped word's result is discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_err_q <= 1'b0;
        end else begin
            if (bus.clr) begin
                parity_err_q <= 1'b0;
            end
            if (load_word) begin
                parity_err_q <= par_bad_d;
            end
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_deser_reg.sv
// Directed, table-driven bench for serial_deser_reg plus hand-written multi-cycle corner sequences.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_serial_deser_reg;
    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] stream;
        logic             msb;
        logic [WIDTH-1:0] gaps;
        logic [WIDTH-1:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   valid_count = 0;
    bit   busy_bad = 1'b0;
    vec_t vectors[7];

    always #5 clk = ~clk;

    serial_deser_reg_if #(.WIDTH(WIDTH)) bus ();

    serial_deser_reg #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.dout_valid === 1'b1) valid_count++;
    endtask

    // Non-sof bits carry an inverted msb_first and gaps carry sof=1 with sin_valid=0; both must be ignored.
    task automatic sendBits(input logic [WIDTH-1:0] stream, input logic msb,
                            input logic [WIDTH-1:0] gaps, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps[i]) begin
                tick();
                if (i > 0 && bus.busy !== 1'b1) busy_bad = 1'b1;
                bus.sin_valid = 1'b0;
                bus.sof       = 1'b1;
                bus.sin       = 1'b1;
            end
            tick();
            if (i > 0 && bus.busy !== 1'b1) busy_bad = 1'b1;
            bus.sin_valid = 1'b1;
            bus.sof       = (i == 0);
            bus.msb_first = (i == 0) ? msb : ~msb;
            bus.sin       = stream[WIDTH-1-i];
        end
    endtask

    task automatic sendParity(input logic b);
        tick();
        if (bus.busy !== 1'b1) busy_bad = 1'b1;
        bus.sin_valid = 1'b1;
        bus.sof       = 1'b0;
        bus.sin       = b;
    endtask

    task automatic finishWord();
        tick();
        bus.sin_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.sin       = 1'b0;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] stream, input logic msb, input logic [WIDTH-1:0] gaps);
        sendBits(stream, msb, gaps, WIDTH);
`ifdef DESER_PARITY_EN
        sendParity(^stream);
`endif
        finishWord();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0] = '{16'hA5C3, 1'b1, 16'h0000, 16'hA5C3};
        vectors[1] = '{16'hA5C3, 1'b0, 16'h0000, 16'hC3A5};
        vectors[2] = '{16'hA5C3, 1'b0, 16'h0925, 16'hC3A5};
        vectors[3] = '{16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
        vectors[4] = '{16'h8001, 1'b0, 16'h4100, 16'h8001};
        vectors[5] = '{16'h1234, 1'b0, 16'h8001, 16'h2C48};
        vectors[6] = '{16'h0000, 1'b1, 16'h0003, 16'h0000};

        bus.clr        = 1'b0;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.sof        = 1'b0;
        bus.msb_first  = 1'b0;
        bus.dout_ready = 1'b1;

        repeat (2) tick();
        checkOutput("reset dout", bus.dout, 0);
        checkOutput("reset dout_valid", bus.dout_valid, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset overflow", bus.overflow, 0);
        checkOutput("reset parity_err", bus.parity_err, 0);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            busy_bad    = 1'b0;
            valid_count = 0;
            applyStimulus(vectors[v].stream, vectors[v].msb, vectors[v].gaps);
            checkOutput($sformatf("vec%0d dout", v), bus.dout, vectors[v].expected);
            checkOutput($sformatf("vec%0d dout_valid", v), bus.dout_valid, 1);
            checkOutput($sformatf("vec%0d busy_low", v), bus.busy, 0);
            checkOutput($sformatf("vec%0d busy_hold", v), busy_bad, 0);
            checkOutput($sformatf("vec%0d parity_err", v), bus.parity_err, 0);
            tick();
            checkOutput($sformatf("vec%0d consumed", v), bus.dout_valid, 0);
            checkOutput($sformatf("vec%0d valid_pulses", v), valid_count, 1);
        end

        // Overflow: second word dropped while the consumer stalls.
        bus.dout_ready = 1'b0;
        applyStimulus(16'h1234, 1'b1, 16'h0000);
        checkOutput("ovf first dout", bus.dout, 16'h1234);
        checkOutput("ovf first valid", bus.dout_valid, 1);
        checkOutput("ovf first flag", bus.overflow, 0);
        applyStimulus(16'hBEEF, 1'b1, 16'h0000);
        checkOutput("ovf held dout", bus.dout, 16'h1234);
        checkOutput("ovf held valid", bus.dout_valid, 1);
        checkOutput("ovf flag set", bus.overflow, 1);
        bus.dout_ready = 1'b1;
        tick();
        checkOutput("ovf drained valid", bus.dout_valid, 0);
        checkOutput("ovf drained dout", bus.dout, 16'h1234);
        checkOutput("ovf sticky", bus.overflow, 1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        checkOutput("ovf cleared", bus.overflow, 0);

        // Back-to-back: new word completes on the edge the held word is consumed.
        bus.dout_ready = 1'b0;
        applyStimulus(16'h1111, 1'b1, 16'h0000);
        sendBits(16'h2222, 1'b1, 16'h0000, WIDTH);
`ifdef DESER_PARITY_EN
        sendParity(1'b0);
`endif
        checkOutput("b2b held valid", bus.dout_valid, 1);
        checkOutput("b2b held dout", bus.dout, 16'h1111);
        bus.dout_ready = 1'b1;
        finishWord();
        checkOutput("b2b new dout", bus.dout, 16'h2222);
        checkOutput("b2b valid stays", bus.dout_valid, 1);
        checkOutput("b2b no overflow", bus.overflow, 0);
        tick();
        checkOutput("b2b consumed", bus.dout_valid, 0);

        // Resync: a partial word is discarded by a fresh sof.
        valid_count = 0;
        sendBits(16'hB3FF, 1'b0, 16'h0000, 7);
        applyStimulus(16'h00FF, 1'b1, 16'h0000);
        checkOutput("resync dout", bus.dout, 16'h00FF);
        checkOutput("resync overflow", bus.overflow, 0);
        tick();
        tick();
        checkOutput("resync valid_pulses", valid_count, 1);

        // Reset mid-word clears everything asynchronously.
        sendBits(16'hFFFF, 1'b1, 16'h0000, 9);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst dout", bus.dout, 0);
        checkOutput("rst busy", bus.busy, 0);
        checkOutput("rst dout_valid", bus.dout_valid, 0);
        checkOutput("rst overflow", bus.overflow, 0);
        @(negedge clk);
        rstn          = 1'b1;
        bus.sin_valid = 1'b0;
        bus.sof       = 1'b0;
        applyStimulus(16'h8001, 1'b1, 16'h0000);
        checkOutput("post-rst dout", bus.dout, 16'h8001);
        checkOutput("post-rst valid", bus.dout_valid, 1);
        tick();

`ifdef DESER_PARITY_EN
        sendBits(16'h0001, 1'b1, 16'h0000, WIDTH);
        sendParity(1'b1);
        finishWord();
        checkOutput("par good dout", bus.dout, 16'h0001);
        checkOutput("par good err", bus.parity_err, 0);
        tick();
        sendBits(16'h0001, 1'b1, 16'h0000, WIDTH);
        sendParity(1'b0);
        finishWord();
        checkOutput("par bad dout", bus.dout, 16'h0001);
        checkOutput("par bad err", bus.parity_err, 1);
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        checkOutput("par cleared", bus.parity_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_deser_reg.md
# serial_deser_reg

Serial-in, parallel-out deserializer: collects a qualified serial bitstream into WIDTH-bit words and presents each completed word on a registered valid/ready output buffer. It is the receive-side counterpart to the parallel shift register datapath: a shift register serializes words onto a line, and this block reconstructs them. Bit order is selectable per word, and loss is flagged when the consumer stalls.

## Interface
- WIDTH, 16, data word width; must be ≥ 2; bit counter is $clog2(WIDTH+1) bits
- clk  in  1  single clock, all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of `overflow` and `parity_err`
- sin  in  1  serial data bit
- sin_valid  in  1  `sin` is sampled this cycle
- sof  in  1  start of word, qualified by `sin_valid`; the bit sampled with it is the first bit of a word
- msb_first  in  1  bit order, sampled only with `sof & sin_valid`: 1 means the first bit lands in dout[WIDTH-1]; 0 means the first bit lands in dout[0]
- dout  out  WIDTH  completed word
- dout_valid  out  1  `dout` holds an unconsumed word
- dout_ready  in  1  consumer accepts; transfer on `dout_valid & dout_ready` at the rising edge
- busy  out  1  word assembly in progress (state ≠ IDLE)
- overflow  out  1  sticky; a completed word was dropped
- parity_err  out  1  parity result for the word in `dout`; tied 0 without DESER_PARITY_EN

## Operation
- States:
  - IDLE: waits for a word start.
  - RECV: collects data bits.
  - PAR: waits for the parity bit; exists only with DESER_PARITY_EN.
- Reset (async, rstn=0): state=IDLE, shift reg=0, count=0, dout=0, dout_valid=0, overflow=0, parity_err=0, busy=0.
- IDLE:
  - `sin_valid & sof`: latch `msb_first`, shift in `sin`, count=1, go to RECV.
  - Any other `sin_valid` bit is ignored.
- RECV: each `sin_valid` cycle shifts in one bit and increments count; cycles without `sin_valid` hold all state.
  - msb_first=1: shift left, new bit enters bit 0.
  - msb_first=0: shift right, new bit enters bit WIDTH-1.
- `sof & sin_valid` while in RECV or PAR: the partial word is discarded silently and assembly restarts with this bit as the first bit; `msb_first` is re-latched.
- Completion (without parity): the WIDTH-th bit is accepted → the word is offered to the output buffer; state goes to IDLE. Each word requires its own `sof`.
- Output buffer, evaluated at the completion edge:
  - Empty, or `dout_ready`=1 that cycle: load dout, dout_valid=1.
  - Full and `dout_ready`=0: drop the word, dout unchanged, overflow=1.
- Consume without a new completion: dout_valid→0; dout keeps its last value.
- `clr` clears `overflow` and `parity_err`. If `clr` and a new overflow occur in the same edge, the overflow wins.

## Timing
- Latency: dout_valid is high in the cycle after the edge that samples the last bit (or the parity bit with DESER_PARITY_EN).
- dout and parity_err are stable while `dout_valid & ~dout_ready`.
- Back-to-back words: a word may complete on the same edge as the previous word is consumed; there is no bubble and dout_valid stays 1.
- busy goes high the cycle after the `sof` edge and low the cycle after completion.
- Throughput: one bit per cycle maximum; WIDTH cycles per word minimum (WIDTH+1 with parity).

## Configuration
- DESER_PARITY_EN defined:
  - After WIDTH data bits the FSM enters PAR and accepts one more `sin_valid` bit.
  - Even parity is checked over WIDTH+1 bits; parity_err is loaded with dout (1 = mismatch).
  - On overflow the dropped word's parity result is discarded.
  - `sof` in PAR restarts assembly.
- DESER_PARITY_EN undefined: no PAR state, parity_err is constant 0, words complete after WIDTH bits.

## Test plan
- MSB-first: `sof` with msb_first=1, stream 1010 0101 1100 0011 at one bit per cycle, dout_ready=1 → dout=0xA5C3, dout_valid high for 1 cycle, one cycle after the last bit.
- LSB-first: same stream with msb_first=0 → dout=0xC3A5; insert random `sin_valid` gaps → same result, and busy stays high through the gaps.
- Overflow: two words 0x1234 then 0xBEEF with dout_ready=0 → dout=0x1234, overflow=1; assert dout_ready → transfer, dout_valid=0; pulse clr → overflow=0.
- Resync: 7 bits, then `sof` with word 0x00FF (msb_first=1) → dout=0x00FF, no overflow, and exactly one dout_valid.
- Reset mid-word: rstn low after 9 bits → all outputs 0 immediately; a following full word 0x8001 → dout=0x8001.
- Parity (with DESER_PARITY_EN): 0x0001 followed by parity bit 1 → parity_err=0; 0x0001 followed by parity bit 0 → parity_err=1; dout=0x0001 in both cases.
